twiddle_scheduler: RTL and testbench

TWIDDLE_SCHEDULER -- requirements
Module: twiddle_scheduler

---
 rtl/fft_pkg.sv | 15 +
 rtl/twiddle_addr_gen.sv | 34 +++
 rtl/twiddle_scheduler.sv | 173 +++++++++++++++++
 tb/tb_twiddle_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: twiddle scheduler FSM encoding and the packing of the
// real/imag halves inside a twiddle word.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Half-word slot of each component: word = {real, imag}.
    localparam int TW_RE_SLOT = 1;
    localparam int TW_IM_SLOT = 0;

endpackage

// File: rtl/twiddle_addr_gen.sv
// Combinational radix-2 DIT decode: stage s and butterfly b -> ROM address and
// the two sample indices of the butterfly.
module twiddle_addr_gen #(
    parameter int N    = 32,
    parameter int LOGN = $clog2(N),
    parameter int SW   = $clog2(LOGN) + 1
) (
    input  logic [SW-1:0]   s,
    input  logic [LOGN-2:0] b,
    output logic [LOGN-1:0] rom_addr,
    output logic [LOGN-1:0] top,
    output logic [LOGN-1:0] bot
);

    logic [LOGN-1:0] one_s;
    logic [LOGN-1:0] mask;
    logic [LOGN-1:0] b_ext;
    logic [LOGN-1:0] b_lo;
    logic [LOGN-1:0] b_hi;

    // b_lo is the position inside a group, b_hi the group number; top has a
    // zero at bit s, so setting that bit yields top + 2^s.
    always_comb begin
        one_s    = LOGN'(1) << s;
        mask     = one_s - LOGN'(1);
        b_ext    = LOGN'(b);
        b_lo     = b_ext & mask;
        b_hi     = b_ext >> s;
        top      = (b_hi << (s + SW'(1))) | b_lo;
        bot      = top | one_s;
        rom_addr = b_lo << (SW'(LOGN - 1) - s);
    end

endmodule

// File: rtl/twiddle_scheduler.sv
// FFT twiddle scheduler: walks every stage/butterfly, fetches twiddles from an
// external ROM and streams them over a valid/ready port. Optional build macro
// TWIDDLE_SCHED_CONJ_EN adds an 'inverse' input that conjugates the twiddles.
module twiddle_scheduler
    import fft_pkg::*;
#(
    parameter int N         = 32,
    parameter int word_size = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
`ifdef TWIDDLE_SCHED_CONJ_EN
    input  logic                          inverse,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(N)-1:0]          rom_addr,
    input  logic [2*word_size-1:0]        rom_data,
    output logic                          tw_valid,
    input  logic                          tw_ready,
    output logic [2*word_size-1:0]        tw_data,
    output logic [$clog2(N)-1:0]          tw_top,
    output logic [$clog2(N)-1:0]          tw_bot,
    output logic [$clog2($clog2(N)):0]    tw_stage,
    output logic                          tw_last
);

    localparam int LOGN = $clog2(N);
    localparam int SW   = $clog2(LOGN) + 1;
    localparam int BW   = LOGN - 1;
    localparam int W2   = 2 * word_size;

    sched_state_t    state, state_nx;
    logic [SW-1:0]   s_q;
    logic [BW-1:0]   b_q;
    logic            load;
    logic            drain_acc;
    logic            is_last;
    logic [LOGN-1:0] addr_c, top_c, bot_c;
    logic [W2-1:0]   data_c;

    logic            vld_p1;
    logic            done_p1;
    logic [W2-1:0]   data_p1;
    logic [LOGN-1:0] top_p1, bot_p1;
    logic [SW-1:0]   stage_p1;
    logic            last_p1;

    twiddle_addr_gen #(.N(N), .LOGN(LOGN), .SW(SW)) u_addr_gen (
        .s        (s_q),
        .b        (b_q),
        .rom_addr (addr_c),
        .top      (top_c),
        .bot      (bot_c)
    );

    assign is_last = (s_q == SW'(LOGN - 1)) && (b_q == {BW{1'b1}});

`ifdef TWIDDLE_SCHED_CONJ_EN
    logic inv_q;
    logic inv_eff;

    function automatic logic signed [word_size-1:0] neg_sat(input logic signed [word_size-1:0] x);
        logic signed [word_size-1:0] most_neg;
        most_neg = {1'b1, {(word_size-1){1'b0}}};
        if (x == most_neg) return ~most_neg;
        return -x;
    endfunction

    // The first butterfly is loaded in the start cycle, before inv_q is written.
    assign inv_eff = (state == ST_IDLE) ? inverse : inv_q;

    always_comb begin
        data_c = rom_data;
        if (inv_eff)
            data_c[TW_IM_SLOT*word_size +: word_size] =
                neg_sat(rom_data[TW_IM_SLOT*word_size +: word_size]);
    end

    always_ff @(posedge clk) begin
        if (reset)
            inv_q <= 1'b0;
        else if (state == ST_IDLE && start)
            inv_q <= inverse;
    end
`else
    assign data_c = rom_data;
`endif

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        drain_acc = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!vld_p1 || tw_ready) begin
                    load = 1'b1;
                    if (is_last)
                        state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tw_ready) begin
                    drain_acc = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            s_q     <= '0;
            b_q     <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            state   <= state_nx;
            done_p1 <= drain_acc;
            if (load) begin
                vld_p1 <= 1'b1;
                if (is_last) begin
                    s_q <= '0;
                    b_q <= '0;
                end else if (b_q == {BW{1'b1}}) begin
                    s_q <= s_q + SW'(1);
                    b_q <= '0;
                end else begin
                    b_q <= b_q + BW'(1);
                end
            end else if (drain_acc) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // p1: output register, loaded only when the previous word is gone
    always_ff @(posedge clk) begin
        if (reset) begin
            data_p1  <= '0;
            top_p1   <= '0;
            bot_p1   <= '0;
            stage_p1 <= '0;
            last_p1  <= 1'b0;
        end else if (load) begin
            data_p1  <= data_c;
            top_p1   <= top_c;
            bot_p1   <= bot_c;
            stage_p1 <= s_q;
            last_p1  <= is_last;
        end
    end

    assign rom_addr = addr_c;
    assign busy     = (state != ST_IDLE);
    assign done     = done_p1;
    assign tw_valid = vld_p1;
    assign tw_data  = data_p1;
    assign tw_top   = top_p1;
    assign tw_bot   = bot_p1;
    assign tw_stage = stage_p1;
    assign tw_last  = last_p1;

endmodule

// File: tb/tb_twiddle_scheduler.sv
// Scoreboard bench for twiddle_scheduler (N=32): a stage/butterfly model fills
// the expected queue at each start; a negedge monitor pops on every transfer.
module tb_twiddle_scheduler;

    localparam int N     = 32;
    localparam int WS    = 16;
    localparam int LOGN  = 5;
    localparam int SW    = 4;
    localparam int TOTAL = (N / 2) * LOGN;

    logic            clk = 1'b0;
    logic            reset, start, busy, done;
    logic [LOGN-1:0] rom_addr, tw_top, tw_bot;
    logic [2*WS-1:0] rom_data, tw_data;
    logic            tw_valid, tw_ready, tw_last;
    logic [SW-1:0]   tw_stage;
`ifdef TWIDDLE_SCHED_CONJ_EN
    logic            inverse;
`endif

    logic [31:0] rom [N];
    assign rom_data = rom[rom_addr];

    twiddle_scheduler #(.N(N), .word_size(WS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
`ifdef TWIDDLE_SCHED_CONJ_EN
        .inverse  (inverse),
`endif
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_data  (tw_data),
        .tw_top   (tw_top),
        .tw_bot   (tw_bot),
        .tw_stage (tw_stage),
        .tw_last  (tw_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          top;
        int          bot;
        int          stage;
        bit          last;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   compared    = 0;
    int   mismatched  = 0;
    int   sched_xfers = 0;
    int   done_cnt    = 0;
    bit   done_due    = 0;
    bit   held        = 0;
    bit   cur_inv     = 0;
    logic [31:0]     h_data;
    logic [LOGN-1:0] h_top, h_bot;
    logic [SW-1:0]   h_stage;
    logic            h_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model_data(input int addr, input bit inv);
        logic [31:0] d;
        logic [15:0] im;
        d  = rom[addr];
        im = d[15:0];
        if (inv) begin
            if (im == 16'h8000) im = 16'h7FFF;
            else                im = 16'(0 - im);
        end
        return {d[31:16], im};
    endfunction

    // Schedule from the textbook definition: s outer, b inner.
    task automatic push_schedule(input bit inv);
        exp_t e;
        for (int s = 0; s < LOGN; s++) begin
            for (int b = 0; b < N / 2; b++) begin
                int p    = 1 << s;
                int addr = (b % p) << (LOGN - 1 - s);
                e.top   = (b / p) * 2 * p + (b % p);
                e.bot   = e.top + p;
                e.stage = s;
                e.data  = model_data(addr, inv);
                e.last  = (s == LOGN - 1) && (b == N / 2 - 1);
                expq.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            held     = 0;
            done_due = 0;
        end else begin
            if (done || done_due) begin
                chk("done_pulse", done, done_due);
                if (done) begin
                    chk("xfers_per_schedule", sched_xfers, TOTAL);
                    chk("busy_low_at_done", busy, 0);
                    done_cnt++;
                    sched_xfers = 0;
                end
            end
            done_due = 0;
            if (held && tw_valid) begin
                chk("stall_data", tw_data, h_data);
                chk("stall_top", tw_top, h_top);
                chk("stall_bot", tw_bot, h_bot);
                chk("stall_stage", tw_stage, h_stage);
                chk("stall_last", tw_last, h_last);
            end
            held = 0;
            if (tw_valid && tw_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_transfer", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    chk("tw_data", tw_data, mon_e.data);
                    chk("tw_top", tw_top, mon_e.top);
                    chk("tw_bot", tw_bot, mon_e.bot);
                    chk("tw_stage", tw_stage, mon_e.stage);
                    chk("tw_last", tw_last, mon_e.last);
                    if (tw_stage == 2 && tw_top == 9) begin
                        chk("s2b5_bot", tw_bot, 13);
                        chk("s2b5_data", tw_data, model_data(4, cur_inv));
                    end
                    sched_xfers++;
                    if (mon_e.last) done_due = 1;
                end
            end else if (tw_valid) begin
                held    = 1;
                h_data  = tw_data;
                h_top   = tw_top;
                h_bot   = tw_bot;
                h_stage = tw_stage;
                h_last  = tw_last;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, tw_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_last"}, tw_last, 0);
        chk({tag, "_data"}, tw_data, 0);
        chk({tag, "_top"}, tw_top, 0);
        chk({tag, "_bot"}, tw_bot, 0);
        chk({tag, "_stage"}, tw_stage, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    task automatic start_sched(input bit inv);
        cur_inv = inv;
        push_schedule(inv);
`ifdef TWIDDLE_SCHED_CONJ_EN
        inverse = inv;
`endif
        start = 1;
        @(posedge clk); #1;
        start = 0;
`ifdef TWIDDLE_SCHED_CONJ_EN
        inverse = 0;
`endif
        chk("first_valid_latency", tw_valid, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        chk("queue_empty_after_done", expq.size(), 0);
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (sched_xfers < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (sched_xfers < target) chk("xfer_wait_timeout", 0, 1);
    endtask

    initial begin
        int d0;
        int n;
        reset    = 1;
        start    = 0;
        tw_ready = 0;
`ifdef TWIDDLE_SCHED_CONJ_EN
        inverse  = 0;
`endif
        for (int i = 0; i < N; i++)
            rom[i] = {16'(16'h1000 + i * 16'h0101), 16'($urandom)};
        rom[0] = 32'h5A82A57E;
        rom[1] = 32'h12348000;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 0;
        @(posedge clk); #1;

        // Full-rate schedule
        tw_ready = 1;
        start_sched(0);
        wait_done(300);

        // Three-cycle stall at transfer 10
        start_sched(0);
        wait_xfers(10);
        tw_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        tw_ready = 1;
        wait_done(300);

        // Start pulses while running are ignored
        d0 = done_cnt;
        start_sched(0);
        repeat (20) @(posedge clk);
        #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        wait_done(300);
        repeat (5) @(posedge clk);
        #1;
        chk("single_done_with_restart", done_cnt - d0, 1);

        // Reset mid-schedule at transfer 40
        d0 = done_cnt;
        start_sched(0);
        wait_xfers(40);
        reset = 1;
        expq.delete();
        sched_xfers = 0;
        @(posedge clk); #1;
        reset = 0;
        check_zero("abort");
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_abort", done_cnt - d0, 0);
        start_sched(0);
        wait_done(300);

        // Random backpressure with stray start pulses while busy
        start_sched(0);
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk); #1;
            tw_ready = ($urandom_range(0, 99) < 60);
            start    = busy && ($urandom_range(0, 19) == 0);
            n++;
        end
        start    = 0;
        tw_ready = 1;
        if (done_cnt == d0) chk("random_done_timeout", 0, 1);
        chk("random_queue_empty", expq.size(), 0);

        // Start in the same cycle as done
        start_sched(0);
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen_for_chain", done, 1);
        start_sched(0);
        wait_done(300);

`ifdef TWIDDLE_SCHED_CONJ_EN
        // Conjugated schedule under random backpressure
        start_sched(1);
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk); #1;
            tw_ready = ($urandom_range(0, 99) < 70);
            n++;
        end
        tw_ready = 1;
        if (done_cnt == d0) chk("conj_done_timeout", 0, 1);
        chk("conj_vector_a", model_data(0, 1), 32'h5A825A82);
        chk("conj_vector_b", model_data(1, 1), 32'h12347FFF);
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1);
    end

endmodule
